// File: rtl/store_buffer_pkg.sv
// ============================================================================
// Module  : store_buffer_pkg
// Brief   : Shared widths, depth defaults and pointer-width helper.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package store_buffer_pkg;

  localparam int DEF_ADDRESS_WIDTH = 32;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_DEPTH         = 4;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sb_youngest_match.sv
// ============================================================================
// Module  : sb_youngest_match
// Brief   : Rotated priority encoder returning the match closest behind tail.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sb_youngest_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic [DEPTH-1:0] match,
  input  logic [PTR_W-1:0] tail,
  output logic             hit,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W-1:0] cand;

  // Walk from oldest (tail-DEPTH) to youngest (tail-1); later hits override.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      cand = tail - PTR_W'(k);
      if (match[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// Module  : store_buffer
// Brief   : Store queue draining into the data RAM with store-to-load forwarding.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int DEPTH         = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDRESS_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0]    st_data,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  output logic                     ld_hit,
  output logic [DATA_WIDTH-1:0]    ld_data,
  input  logic                     mem_grant,
  output logic                     mem_WE,
  output logic [ADDRESS_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0]    mem_WD,
  output logic                     empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_d [DEPTH];
  logic [DATA_WIDTH-1:0]    data_q [DEPTH];
  logic [DATA_WIDTH-1:0]    data_d [DEPTH];
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic                     accept;
  logic                     drain;
  logic [DEPTH-1:0]         match;
  logic                     fwd_hit;
  logic [PTR_W-1:0]         fwd_idx;

  assign st_ready = (count_q != CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign mem_WE   = (count_q != '0) && mem_grant;
  assign mem_A    = addr_q[head_q];
  assign mem_WD   = data_q[head_q];

  assign accept = st_valid && st_ready;
  assign drain  = mem_WE;

  // Accept and drain never target the same slot: tail==head only when empty or full.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (accept) begin
      addr_d[tail_q]  = st_addr;
      data_d[tail_q]  = st_data;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    case ({accept, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_match
      assign match[g] = valid_q[g] && (addr_q[g] == ld_addr);
    end
  endgenerate

  sb_youngest_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_youngest (
    .match (match),
    .tail  (tail_q),
    .hit   (fwd_hit),
    .idx   (fwd_idx)
  );

  assign ld_hit  = fwd_hit;
  assign ld_data = fwd_hit ? data_q[fwd_idx] : '0;

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// Module  : tb_store_buffer
// Brief   : Queue-model checked bench for store_buffer (directed + random).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_store_buffer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_grant;
  logic          mem_WE;
  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_WD;
  logic          empty;

  int checks = 0;
  int errors = 0;

  entry_t q[$];
  entry_t exp_log[$];
  entry_t act_log[$];

  store_buffer #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .ld_data   (ld_data),
    .mem_grant (mem_grant),
    .mem_WE    (mem_WE),
    .mem_A     (mem_A),
    .mem_WD    (mem_WD),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs follow directly from the pending-store list.
  task automatic compare();
    bit            eh;
    logic [DW-1:0] ed;
    eh = 1'b0;
    ed = '0;
    foreach (q[i]) if (q[i].a == ld_addr) begin eh = 1'b1; ed = q[i].d; end
    chk("st_ready", st_ready, q.size() < DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("mem_WE", mem_WE, (q.size() != 0) && mem_grant);
    if (q.size() != 0 && mem_grant) begin
      chk("mem_A", mem_A, q[0].a);
      chk("mem_WD", mem_WD, q[0].d);
    end
    chk("ld_hit", ld_hit, eh);
    if (eh) chk("ld_data", ld_data, ed);
    if (mem_WE === 1'b1) act_log.push_back('{a: mem_A, d: mem_WD});
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic g, input logic [AW-1:0] la);
    st_valid  = v;
    st_addr   = a;
    st_data   = d;
    mem_grant = g;
    ld_addr   = la;
    #3;
    compare();
  endtask

  task automatic advance(output bit acc);
    bit drn;
    acc = st_valid && (q.size() < DEPTH);
    drn = (q.size() != 0) && mem_grant;
    if (acc) exp_log.push_back('{a: st_addr, d: st_data});
    if (drn) void'(q.pop_front());
    if (acc) q.push_back('{a: st_addr, d: st_data});
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic g, input logic [AW-1:0] la);
    bit acc;
    drive(v, a, d, g, la);
    advance(acc);
  endtask

  task automatic compare_logs(input string name);
    chk({name, "_nwrites"}, act_log.size(), exp_log.size());
    foreach (exp_log[i]) begin
      if (i < act_log.size()) begin
        chk({name, "_addr"}, act_log[i].a, exp_log[i].a);
        chk({name, "_data"}, act_log[i].d, exp_log[i].d);
      end
    end
    act_log.delete();
    exp_log.delete();
  endtask

  initial begin
    bit acc;
    int n;
    logic [AW-1:0] pool [4];
    pool[0] = 32'h40; pool[1] = 32'h44; pool[2] = 32'h48; pool[3] = 32'h4C;

    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_addr = '0; mem_grant = 1'b0;
    @(posedge clk); #1;
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_mem_WE", mem_WE, 1'b0);
    chk("rst_ld_hit", ld_hit, 1'b0);
    chk("rst_mem_A", mem_A, 32'h0);
    chk("rst_mem_WD", mem_WD, 32'h0);
    chk("rst_ld_data", ld_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single store, drained on the following cycle.
    drive(1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 32'h10);
    chk("t1_no_same_cycle_drain", mem_WE, 1'b0);
    chk("t1_no_same_cycle_fwd", ld_hit, 1'b0);
    advance(acc);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h10);
    chk("t1_WE", mem_WE, 1'b1);
    chk("t1_A", mem_A, 32'h10);
    chk("t1_WD", mem_WD, 32'hDEADBEEF);
    chk("t1_drain_fwd", ld_data, 32'hDEADBEEF);
    advance(acc);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    chk("t1_empty", empty, 1'b1);
    advance(acc);
    compare_logs("t1");

    // Fill with grant low, then drain in order.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 1'b0, 32'h0);
    drive(1'b1, 32'h99, 32'h99, 1'b1, 32'h8);
    chk("t2_full_ready", st_ready, 1'b0);
    chk("t2_first_A", mem_A, 32'h0);
    chk("t2_fwd_08", ld_data, 32'hA2);
    advance(acc);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    chk("t2_ready_after_drain", st_ready, 1'b1);
    chk("t2_second_A", mem_A, 32'h4);
    advance(acc);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    compare_logs("t2");

    // Youngest-match forwarding.
    cyc(1'b1, 32'h20, 32'h1111, 1'b0, 32'h20);
    cyc(1'b1, 32'h20, 32'h2222, 1'b0, 32'h20);
    drive(1'b1, 32'h30, 32'h3333, 1'b0, 32'h20);
    chk("t3_hit", ld_hit, 1'b1);
    chk("t3_data", ld_data, 32'h2222);
    advance(acc);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h24);
    chk("t3_miss", ld_hit, 1'b0);
    advance(acc);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h30);
    chk("t3_next_cycle_fwd", ld_data, 32'h3333);
    advance(acc);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
    compare_logs("t3");

    // Wrap-around: 10 stores, grant toggling every cycle.
    n = 0;
    for (int c = 0; c < 80 && (n < 10 || q.size() != 0); c++) begin
      drive(n < 10, 32'h100 + 32'(n * 4), 32'hC000 + 32'(n), c[0], 32'h100 + 32'($urandom_range(0, 9) * 4));
      advance(acc);
      if (acc) n++;
    end
    chk("t4_all_accepted", n, 10);
    compare_logs("t4");

    // Full buffer with a store and a drain in the same cycle.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h200 + 32'(i * 4), 32'hB0 + 32'(i), 1'b0, 32'h0);
    drive(1'b1, 32'h5C, 32'h5C5C, 1'b1, 32'h5C);
    chk("t5_no_bypass", st_ready, 1'b0);
    chk("t5_drain", mem_WE, 1'b1);
    advance(acc);
    chk("t5_not_accepted", acc, 1'b0);
    drive(1'b1, 32'h5C, 32'h5C5C, 1'b0, 32'h5C);
    chk("t5_ready_next", st_ready, 1'b1);
    advance(acc);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h5C);
    compare_logs("t5");

    // Randomised traffic over a small address pool.
    for (int c = 0; c < 400; c++)
      cyc($urandom_range(0, 2) != 0, pool[$urandom_range(0, 3)], $urandom,
          $urandom_range(0, 1) == 1, pool[$urandom_range(0, 3)]);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    compare_logs("rand");

    // Reset with pending stores.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + 32'(i * 4), 32'hE0 + 32'(i), 1'b0, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h300);
    chk("t6_pre_WE", mem_WE, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_WE", mem_WE, 1'b0);
    chk("t6_empty", empty, 1'b1);
    chk("t6_ready", st_ready, 1'b1);
    chk("t6_ld_hit", ld_hit, 1'b0);
    chk("t6_ld_data", ld_data, 32'h0);
    q.delete();
    act_log.delete();
    exp_log.delete();
    @(posedge clk); #1;
    chk("t6_WE_in_reset", mem_WE, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'h300);
    compare_logs("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
